// File: rtl/clksel_sched.sv
// clksel_sched: sequences the CPU clock switch between the fast divided clock
// and the slow host clock. It asks for the slow clock while a host-bus access
// is pending, and acknowledges the access only after the switch confirms the
// slow clock. Divider changes are applied only while the slow clock is confirmed.
// Optional build macro CLKSEL_DWELL_EN: the block holds the slow clock for at
// least LS_DWELL cycles before it returns to the fast clock.
module clksel_sched #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int LS_DWELL    = 4
) (
  input  logic       hsclk_in,
  input  logic       rst,
  input  logic       ls_req,
  input  logic       force_ls,
  input  logic [1:0] cfg_div_sel,
  input  logic       cfg_div_we,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       ls_ack,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {TO_LS, LS_RUN, TO_HS, HS_RUN} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] hs_sync, ls_sync;
  logic                   hs_s, ls_s;
  logic                   div_pending, div_apply;
  logic [1:0]             div_pend_val;
  logic [7:0]             tmo_cnt;
  logic                   in_trans, enter_trans;
  logic                   dwell_ok;

  // Synchronise the asynchronous switch feedback before any decision uses it.
  // NOTE: state updates use non-blocking assignments, so every flop samples the
  // pre-edge value of its neighbour and the shift chain does not collapse.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      hs_sync <= '0;
      ls_sync <= '0;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsclk_selected};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], lsclk_selected};
    end
  end

  assign hs_s = hs_sync[SYNC_STAGES-1];
  assign ls_s = ls_sync[SYNC_STAGES-1];

  // State register. Reset lands in TO_LS, which matches the switch's own reset-to-slow state.
  always_ff @(posedge hsclk_in) begin
    if (rst) state <= TO_LS;
    else     state <= state_nxt;
  end

`ifdef CLKSEL_DWELL_EN
  localparam logic [7:0] DWELL_MIN = 8'(LS_DWELL);
  logic [7:0] dwell_cnt;

  // Dwell counter: counts the cycles spent in LS_RUN and saturates. It restarts on each LS_RUN entry.
  always_ff @(posedge hsclk_in) begin
    if (rst)                                      dwell_cnt <= '0;
    else if (state != LS_RUN && state_nxt == LS_RUN) dwell_cnt <= '0;
    else if (state == LS_RUN && dwell_cnt != 8'hFF)  dwell_cnt <= dwell_cnt + 8'd1;
  end

  assign dwell_ok = (dwell_cnt >= DWELL_MIN);
`else
  assign dwell_ok = 1'b1;
`endif

  // Next-state and handshake outputs. The outputs are decoded from the state.
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    hsclk_sel = 1'b0;
    busy      = 1'b0;
    ls_ack    = 1'b0;
    case (state)
      TO_LS: begin
        busy = 1'b1;
        if (ls_s && !hs_s) state_nxt = LS_RUN;
      end
      LS_RUN: begin
        ls_ack = ls_req;
        if (!ls_req && !force_ls && !div_pending && dwell_ok) state_nxt = TO_HS;
      end
      TO_HS: begin
        hsclk_sel = 1'b1;
        busy      = 1'b1;
        if (hs_s && !ls_s) state_nxt = HS_RUN;
      end
      HS_RUN: begin
        hsclk_sel = 1'b1;
        if (ls_req || force_ls || div_pending) state_nxt = TO_LS;
      end
      default: state_nxt = TO_LS;
    endcase
  end

  assign div_apply = (state == LS_RUN) && div_pending;

  // Divider staging. A write is held pending and reaches the switch only in LS_RUN.
  // A write that coincides with an apply stays pending for the next cycle.
  // NOTE: all registers here, including the small staging value, are in the
  // reset branch, so no control flop starts the run with an unknown value.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      cpuclk_div_sel <= 2'b00;
      div_pend_val   <= 2'b00;
      div_pending    <= 1'b0;
    end else begin
      if (div_apply) cpuclk_div_sel <= div_pend_val;
      if (cfg_div_we) begin
        div_pend_val <= cfg_div_sel;
        div_pending  <= 1'b1;
      end else if (div_apply) begin
        div_pending  <= 1'b0;
      end
    end
  end

  assign in_trans    = (state == TO_LS) || (state == TO_HS);
  assign enter_trans = (state_nxt != state) && ((state_nxt == TO_LS) || (state_nxt == TO_HS));

  // Confirmation timeout. The counter saturates. The error flag is sticky and
  // rises TIMEOUT cycles after entry into a transition state.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (enter_trans)                        tmo_cnt <= '0;
      else if (in_trans && tmo_cnt != 8'hFF)  tmo_cnt <= tmo_cnt + 8'd1;
      if (in_trans && tmo_cnt >= TMO_LAST)    timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clksel_sched.sv
// Directed bench for clksel_sched, with a behavioural clock-switch model.
// The switch model drops both confirmations for a break-before-make gap,
// waits SW_DLY cycles, and then confirms the requested clock.
module tb_clksel_sched;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;
  localparam int LS_DWELL    = 4;
  localparam int SW_DLY      = 2;
  // Cycles from a select change until the new confirmation appears at the switch pins.
  localparam int SW_CYC      = SW_DLY + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       ls_req, force_ls, cfg_div_we;
  logic [1:0] cfg_div_sel;
  logic       hs_fb, ls_fb;
  logic       hsclk_sel, ls_ack, busy, timeout_err;
  logic [1:0] cpuclk_div_sel;

  // Switch model state
  logic freeze, tgt;
  int   dly;

  int checks = 0;
  int fails  = 0;

  clksel_sched #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .LS_DWELL(LS_DWELL)) dut (
    .hsclk_in(clk), .rst(rst), .ls_req(ls_req), .force_ls(force_ls),
    .cfg_div_sel(cfg_div_sel), .cfg_div_we(cfg_div_we),
    .hsclk_selected(hs_fb), .lsclk_selected(ls_fb),
    .hsclk_sel(hsclk_sel), .cpuclk_div_sel(cpuclk_div_sel), .ls_ack(ls_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Clock switch model. It acts on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    if (!freeze) begin
      if (hsclk_sel !== tgt) begin
        tgt   = hsclk_sel;
        dly   = SW_DLY;
        hs_fb = 1'b0;
        ls_fb = 1'b0;
      end else if (dly != 0) begin
        dly = dly - 1;
      end else begin
        hs_fb = tgt;
        ls_fb = !tgt;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    freeze = 1'b0;
    tgt    = 1'b0;
    dly    = 0;
    hs_fb  = 1'b0;
    ls_fb  = 1'b1;
  endtask

  // Tick until the block is in HS_RUN (fast clock selected, not busy). The
  // result is the number of edges taken, or -1 if the bound runs out.
  task automatic wait_hs_run(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (hsclk_sel === 1'b1 && busy === 1'b0) begin n = i; break; end
    end
  endtask

  task automatic wait_ls_run(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (hsclk_sel === 1'b0 && busy === 1'b0) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; ls_req = 1'b0; force_ls = 1'b0; cfg_div_we = 1'b0; cfg_div_sel = 2'b00;
    model_reset();
    tick(); tick();
    checks++; if (hsclk_sel !== 1'b0) begin fails++; $display("FAIL rst_hsclk_sel: got %b expected 0", hsclk_sel); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b expected 1", busy); end
    checks++; if (ls_ack !== 1'b0) begin fails++; $display("FAIL rst_ls_ack: got %b expected 0", ls_ack); end
    checks++; if (cpuclk_div_sel !== 2'b00) begin fails++; $display("FAIL rst_div: got %b expected 00", cpuclk_div_sel); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    rst = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL sync_busy_still: got %b expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0 || hsclk_sel !== 1'b0) begin fails++; $display("FAIL ls_run_entry: busy=%b hsclk_sel=%b expected 0/0", busy, hsclk_sel); end
    checks++; if (cpuclk_div_sel !== 2'b00) begin fails++; $display("FAIL ls_run_div: got %b expected 00", cpuclk_div_sel); end
`ifdef CLKSEL_DWELL_EN
    wait_hs_run(n);
    checks++; if (n < 0) begin fails++; $display("FAIL first_hs_run: got timeout expected HS_RUN"); end
`else
    tick();
    checks++; if (hsclk_sel !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL to_hs_entry: hsclk_sel=%b busy=%b expected 1/1", hsclk_sel, busy); end
    wait_hs_run(n);
    checks++; if (n !== SW_CYC + SYNC_STAGES + 1) begin fails++; $display("FAIL hs_run_latency: got %0d expected %0d", n, SW_CYC + SYNC_STAGES + 1); end
`endif
  endtask

  task automatic test_ls_req();
    int n;
    ls_req = 1'b1;
    tick();
    checks++; if (hsclk_sel !== 1'b0 || busy !== 1'b1 || ls_ack !== 1'b0) begin fails++; $display("FAIL ls_req_drop_hs: hsclk_sel=%b busy=%b ls_ack=%b expected 0/1/0", hsclk_sel, busy, ls_ack); end
    n = -1;
    for (int i = 2; i <= 60; i++) begin
      tick();
      if (ls_ack === 1'b1) begin n = i; break; end
    end
    checks++; if (n !== 1 + SW_CYC + SYNC_STAGES + 1) begin fails++; $display("FAIL ls_ack_latency: got %0d expected %0d", n, 1 + SW_CYC + SYNC_STAGES + 1); end
    ls_req = 1'b0;
    #1;
    checks++; if (ls_ack !== 1'b0) begin fails++; $display("FAIL ls_ack_release: got %b expected 0", ls_ack); end
    wait_hs_run(n);
    checks++; if (n < 0) begin fails++; $display("FAIL ls_req_return_hs: got timeout expected HS_RUN"); end
  endtask

  task automatic test_div();
    int n;
    cfg_div_sel = 2'b01; cfg_div_we = 1'b1;
    tick();
    cfg_div_we = 1'b0;
    checks++; if (cpuclk_div_sel !== 2'b00) begin fails++; $display("FAIL div_hold_in_hs: got %b expected 00", cpuclk_div_sel); end
    wait_ls_run(n);
    checks++; if (n !== SW_CYC + SYNC_STAGES + 2) begin fails++; $display("FAIL div_ls_entry: got %0d expected %0d", n, SW_CYC + SYNC_STAGES + 2); end
    checks++; if (cpuclk_div_sel !== 2'b00) begin fails++; $display("FAIL div_before_apply: got %b expected 00", cpuclk_div_sel); end
    cfg_div_sel = 2'b10; cfg_div_we = 1'b1;
    tick();
    cfg_div_we = 1'b0;
    checks++; if (cpuclk_div_sel !== 2'b01) begin fails++; $display("FAIL div_apply_01: got %b expected 01", cpuclk_div_sel); end
    tick();
    checks++; if (cpuclk_div_sel !== 2'b10 || hsclk_sel !== 1'b0) begin fails++; $display("FAIL div_apply_10: div=%b hsclk_sel=%b expected 10/0", cpuclk_div_sel, hsclk_sel); end
`ifndef CLKSEL_DWELL_EN
    tick();
    checks++; if (hsclk_sel !== 1'b1) begin fails++; $display("FAIL div_exit_ls: got %b expected 1", hsclk_sel); end
`endif
    wait_hs_run(n);
    checks++; if (n < 0 || cpuclk_div_sel !== 2'b10) begin fails++; $display("FAIL div_back_hs: n=%0d div=%b expected HS_RUN/10", n, cpuclk_div_sel); end
  endtask

  task automatic test_force_ls();
    int n, bad;
    force_ls = 1'b1;
    wait_ls_run(n);
    checks++; if (n < 0) begin fails++; $display("FAIL force_ls_enter: got timeout expected LS_RUN"); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hsclk_sel !== 1'b0 || ls_ack !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL force_ls_hold: got %0d bad cycles expected 0", bad); end
    force_ls = 1'b0;
    tick();
    checks++; if (hsclk_sel !== 1'b1) begin fails++; $display("FAIL force_ls_release: got %b expected 1", hsclk_sel); end
    wait_hs_run(n);
    checks++; if (n < 0) begin fails++; $display("FAIL force_ls_back_hs: got timeout expected HS_RUN"); end
  endtask

  task automatic test_back_to_back();
    int n, bad, exp_n;
    ls_req = 1'b1;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ls_ack === 1'b1) begin n = i; break; end
    end
    checks++; if (n < 0) begin fails++; $display("FAIL b2b_ack: got timeout expected ls_ack"); end
    tick();
    ls_req = 1'b0;
    n = -1;
    for (int i = 2; i <= 60; i++) begin
      tick();
      if (hsclk_sel === 1'b1) begin n = i; break; end
    end
`ifdef CLKSEL_DWELL_EN
    exp_n = LS_DWELL + 1;
`else
    exp_n = 2;
`endif
    checks++; if (n !== exp_n) begin fails++; $display("FAIL dwell_exit: got %0d expected %0d", n, exp_n); end
    // ls_req rises again while the switch to the fast clock is committed.
    ls_req = 1'b1;
    bad = 0;
    for (int i = 0; i < SW_CYC + SYNC_STAGES + 1; i++) begin
      tick();
      if (hsclk_sel !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL to_hs_no_abort: got %0d bad cycles expected 0", bad); end
    tick();
    checks++; if (hsclk_sel !== 1'b0) begin fails++; $display("FAIL b2b_reenter_ls: got %b expected 0", hsclk_sel); end
    ls_req = 1'b0;
    wait_ls_run(n);
    wait_hs_run(n);
    checks++; if (n < 0) begin fails++; $display("FAIL b2b_back_hs: got timeout expected HS_RUN"); end
  endtask

  task automatic test_timeout();
    int n;
    ls_req = 1'b1;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ls_ack === 1'b1) begin n = i; break; end
    end
    checks++; if (n < 0) begin fails++; $display("FAIL tmo_setup_ack: got timeout expected ls_ack"); end
    freeze = 1'b1;
    ls_req = 1'b0;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (hsclk_sel === 1'b1) begin n = i; break; end
    end
    checks++; if (n < 0) begin fails++; $display("FAIL tmo_enter_to_hs: got timeout expected hsclk_sel=1"); end
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL tmo_early: got %b expected 0", timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_flag: got %b expected 1", timeout_err); end
    tick(); tick(); tick();
    checks++; if (timeout_err !== 1'b1 || hsclk_sel !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL tmo_sticky: err=%b hsclk_sel=%b busy=%b expected 1/1/1", timeout_err, hsclk_sel, busy); end
    model_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (timeout_err !== 1'b0 || hsclk_sel !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL tmo_reset: err=%b hsclk_sel=%b busy=%b expected 0/0/1", timeout_err, hsclk_sel, busy); end
    checks++; if (cpuclk_div_sel !== 2'b00) begin fails++; $display("FAIL tmo_reset_div: got %b expected 00", cpuclk_div_sel); end
    wait_hs_run(n);
    checks++; if (n < 0) begin fails++; $display("FAIL tmo_recover: got timeout expected HS_RUN"); end
  endtask

  initial begin
    test_reset();
    test_ls_req();
    test_div();
    test_force_ls();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
